// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequencing and result stage around an external 16x16 combinational
// array multiplier. Operands are registered into the array, held for a fixed
// settle window (the array's adder chain is a multicycle path), and the product
// halves are then captured into the CPU-visible LO/HI registers.
//
// Timeline for an accepted start at edge E0 (SETTLE_CYCLES = N):
//   E0        : operands latched into mul_a/mul_b, counter loaded with N-1
//   E1..EN-1  : counter decrements, operands held steady
//   EN        : LO/HI/ovf captured from the array, done set for one cycle
// busy is high from just after E0 up to and including the capture edge.

module mul_seq_ctrl #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ovf
);

  // The settle counter is 4 bits wide, so the window must fit in 1..15 edges.
  // A zero-length window would capture on the same edge the operands are
  // latched, i.e. before the array has seen them.
  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $fatal(1, "mul_seq_ctrl: SETTLE_CYCLES must be within 1..15");
    end
  endgenerate

  // Counter value loaded on accept; the capture happens once it has run down to 0.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] mul_a_q;
  logic [WIDTH-1:0] mul_b_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             ovf_q;
  logic             done_q;

  // Qualifiers derived from the current state.
  logic start_accept;
  logic capture_now;

  // Decode accept and capture conditions from the current state.
  always_comb begin
    start_accept = (state_q == ST_IDLE) && start;
    capture_now  = (state_q == ST_SETTLE) && (cnt_q == 4'd0);
  end

  // Sequencer: operand latch, settle countdown, product capture and direct HI/LO writes.
  // Within one edge a capture is assigned after the direct writes, so a capture
  // overrides a coinciding hi_we/lo_we.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // done is a strobe: cleared on every edge that does not set it.
      done_q <= 1'b0;

      // CPU move-to-HI/LO, honoured in any state.
      if (hi_we) begin
        hi_q <= wdata;
      end
      if (lo_we) begin
        lo_q <= wdata;
      end

      unique case (state_q)
        ST_IDLE: begin
          // Operands are only loaded on accept so the array stays quiet when idle.
          if (start_accept) begin
            mul_a_q <= op_a;
            mul_b_q <= op_b;
            cnt_q   <= CNT_INIT;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // start is deliberately not looked at here: no queueing while busy.
          if (capture_now) begin
            lo_q    <= mul_lo;
            hi_q    <= mul_hi;
            ovf_q   <= |mul_hi;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // busy follows the state directly so the issue stage can stall in the same cycle.
  always_comb begin
    busy = (state_q == ST_SETTLE);
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign ovf   = ovf_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed testbench for mul_seq_ctrl. The external array multiplier is modelled
// as a plain product of the registered operands. Three instances are used: the
// default settle window (4) and the two extremes (1 and 15).

module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        hi_we;
  logic        lo_we;
  logic [15:0] wdata;

  logic [15:0] mul_a, mul_b, hi, lo;
  logic        busy, done, ovf;
  logic [31:0] prod;

  logic        start_s1, start_s15;
  logic [15:0] mul_a_s1, mul_b_s1, hi_s1, lo_s1;
  logic [15:0] mul_a_s15, mul_b_s15, hi_s15, lo_s15;
  logic        busy_s1, done_s1, ovf_s1, busy_s15, done_s15, ovf_s15;
  logic [31:0] prod_s1, prod_s15;

  int tests_run;
  int tests_failed;

  // Array multiplier models
  assign prod     = {16'h0, mul_a} * {16'h0, mul_b};
  assign prod_s1  = {16'h0, mul_a_s1} * {16'h0, mul_b_s1};
  assign prod_s15 = {16'h0, mul_a_s15} * {16'h0, mul_b_s15};

  mul_seq_ctrl #(.WIDTH(16), .SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_lo(prod[15:0]), .mul_hi(prod[31:16]),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .ovf(ovf)
  );

  mul_seq_ctrl #(.WIDTH(16), .SETTLE_CYCLES(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s1), .op_a(op_a), .op_b(op_b),
    .mul_a(mul_a_s1), .mul_b(mul_b_s1), .mul_lo(prod_s1[15:0]), .mul_hi(prod_s1[31:16]),
    .hi_we(1'b0), .lo_we(1'b0), .wdata(16'h0000),
    .busy(busy_s1), .done(done_s1), .hi(hi_s1), .lo(lo_s1), .ovf(ovf_s1)
  );

  mul_seq_ctrl #(.WIDTH(16), .SETTLE_CYCLES(15)) u_dut_s15 (
    .clk(clk), .rst_n(rst_n), .start(start_s15), .op_a(op_a), .op_b(op_b),
    .mul_a(mul_a_s15), .mul_b(mul_b_s15), .mul_lo(prod_s15[15:0]), .mul_hi(prod_s15[31:16]),
    .hi_we(1'b0), .lo_we(1'b0), .wdata(16'h0000),
    .busy(busy_s15), .done(done_s15), .hi(hi_s15), .lo(lo_s15), .ovf(ovf_s15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start on the default instance; returns 1 unit after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    start_s1  = 1'b0;
    start_s15 = 1'b0;
    op_a      = 16'h0;
    op_b      = 16'h0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    wdata     = 16'h0;

    // Reset state
    tick();
    tick();
    check_eq("rst_hi", {16'h0, hi}, 32'h0);
    check_eq("rst_lo", {16'h0, lo}, 32'h0);
    check_eq("rst_flags", {29'h0, busy, done, ovf}, 32'h0);
    check_eq("rst_mul_a", {16'h0, mul_a}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Basic 3*7: busy through E4, done after E4
    issue(16'h0003, 16'h0007);
    check_eq("basic_busy_e0", {31'h0, busy}, 32'h1);
    check_eq("basic_mul_a", {16'h0, mul_a}, 32'h3);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("basic_wait_busy_done", {30'h0, busy, done}, 32'h2);
    end
    tick();
    check_eq("basic_done", {30'h0, busy, done}, 32'h1);
    check_eq("basic_lo", {16'h0, lo}, 32'h0015);
    check_eq("basic_hi", {16'h0, hi}, 32'h0000);
    check_eq("basic_ovf", {31'h0, ovf}, 32'h0);
    tick();
    check_eq("basic_done_drop", {31'h0, done}, 32'h0);

    // Full-scale FFFF*FFFF = FFFE0001
    issue(16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 4; i++) tick();
    check_eq("full_done", {31'h0, done}, 32'h1);
    check_eq("full_lo", {16'h0, lo}, 32'h0001);
    check_eq("full_hi", {16'h0, hi}, 32'hFFFE);
    check_eq("full_ovf", {31'h0, ovf}, 32'h1);
    tick();

    // Ignore start while busy, then back-to-back start in the done cycle
    issue(16'h0002, 16'h0005);            // E0
    op_a  = 16'h1234;
    op_b  = 16'h1234;
    start = 1'b1;
    tick();                               // E1: must be ignored
    start = 1'b0;
    check_eq("ign_mul_a", {16'h0, mul_a}, 32'h0002);
    check_eq("ign_mul_b", {16'h0, mul_b}, 32'h0005);
    tick();
    tick();
    tick();                               // E4: capture of 2*5
    check_eq("ign_done", {31'h0, done}, 32'h1);
    check_eq("ign_lo", {16'h0, lo}, 32'h000A);
    check_eq("ign_ovf_clear", {31'h0, ovf}, 32'h0);
    issue(16'h0100, 16'h0100);            // E5: accepted in done cycle
    check_eq("b2b_busy", {30'h0, busy, done}, 32'h2);
    check_eq("b2b_mul_a", {16'h0, mul_a}, 32'h0100);
    tick();
    tick();
    tick();                               // E8
    check_eq("b2b_not_yet", {31'h0, done}, 32'h0);
    tick();                               // E9
    check_eq("b2b_done", {31'h0, done}, 32'h1);
    check_eq("b2b_hi", {16'h0, hi}, 32'h0001);
    check_eq("b2b_lo", {16'h0, lo}, 32'h0000);
    check_eq("b2b_ovf", {31'h0, ovf}, 32'h1);
    tick();

    // Collision: hi_we on the capture edge loses; lo_we while busy is honoured
    issue(16'h0003, 16'h0007);
    lo_we = 1'b1;
    wdata = 16'h7777;
    tick();                               // E1
    lo_we = 1'b0;
    check_eq("busy_lo_we", {16'h0, lo}, 32'h7777);
    tick();
    tick();                               // E3
    hi_we = 1'b1;
    wdata = 16'hABCD;
    tick();                               // E4: capture wins
    hi_we = 1'b0;
    check_eq("coll_hi", {16'h0, hi}, 32'h0000);
    check_eq("coll_lo", {16'h0, lo}, 32'h0015);
    check_eq("coll_done", {31'h0, done}, 32'h1);
    tick();
    lo_we = 1'b1;
    wdata = 16'h5555;
    tick();
    lo_we = 1'b0;
    check_eq("idle_lo_we", {16'h0, lo}, 32'h5555);
    check_eq("idle_we_done", {31'h0, done}, 32'h0);
    check_eq("idle_we_ovf", {31'h0, ovf}, 32'h0);
    hi_we = 1'b1;
    wdata = 16'h00C3;
    tick();
    hi_we = 1'b0;
    check_eq("idle_hi_we", {16'h0, hi}, 32'h00C3);

    // Reset mid-SETTLE discards the multiply
    issue(16'h0009, 16'h0009);
    tick();                               // E1
    rst_n = 1'b0;
    tick();
    tick();
    check_eq("mid_rst_hilo", {hi, lo}, 32'h0);
    check_eq("mid_rst_flags", {29'h0, busy, done, ovf}, 32'h0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    check_eq("mid_rst_no_done", {31'h0, seen}, 32'h0);

    // Settle window extremes: done exactly 1 and 15 edges after start
    op_a     = 16'h0005;
    op_b     = 16'h0006;
    start_s1 = 1'b1;
    tick();
    start_s1 = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done_s1 && n < 40);
    check_eq("s1_latency", n, 32'd1);
    check_eq("s1_lo", {16'h0, lo_s1}, 32'h001E);

    op_a      = 16'h8000;
    op_b      = 16'h0004;
    start_s15 = 1'b1;
    tick();
    start_s15 = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done_s15 && n < 40);
    check_eq("s15_latency", n, 32'd15);
    check_eq("s15_hilo", {hi_s15, lo_s15}, 32'h0002_0000);
    check_eq("s15_ovf", {31'h0, ovf_s15}, 32'h1);
    tick();
    check_eq("s15_done_drop", {31'h0, done_s15}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
